ad9361_tx_framer: RTL and testbench
===================================

// Module: ad9361_tx_framer
// PURPOSE
//  Transmit-side counterpart of the AD9361 CMOS DDR receive path. Buffers 12-bit I/Q samples
//  from the DSP side and drives per-phase data and TX_FRAME values to the DDR output
//  primitives (DR1_LOGIC_ODDR, instantiated outside this block) toward P1_DATA/TX_FRAME.
//  Lane mapping mirrors receive (he=Q, le=I), so an RX-to-TX loopback preserves I/Q order.
//  A priming state machine prevents underflow at start-up and after a starvation event.
// PARAMETERS
//  FIFO_AW    3  FIFO address width; depth = 2**FIFO_AW = 8 samples
//  PRIME_LVL  4  FIFO level (1..2**FIFO_AW) required before streaming starts or restarts
// PORTS
//  sys_clk        in   1         AD9361 data-rate clock (buffered DATA_CLK), sole clock
//  sys_nrst       in   1         async active-low reset
//  tx_en          in   1         transmit enable; low = flush and idle
//  s_valid        in   1         sample valid
//  s_ready        out  1         sample accepted when s_valid & s_ready at posedge
//  s_i            in   16        I sample; bits [11:0] used, [15:12] ignored
//  s_q            in   16        Q sample; bits [11:0] used, [15:12] ignored
//  d_he           out  12        rising-phase data to ODDR (Q)
//  d_le           out  12        falling-phase data to ODDR (I)
//  frm_he         out  1         rising-phase TX_FRAME
//  frm_le         out  1         falling-phase TX_FRAME
//  tx_active      out  1         high while state == RUN
//  underflow      out  1         one-cycle pulse on starvation
//  underflow_cnt  out  16        saturating starvation count
//  cnt_clr        in   1         synchronous clear of underflow_cnt
//  fifo_level     out  FIFO_AW+1 current FIFO occupancy
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty, all outputs 0 (s_ready=0, d_*=0, frm_*=0, cnt=0).
//  - s_ready = tx_en & (fifo_level < 2**FIFO_AW), combinational from registered level
//    only. No pop bypass: s_ready stays low while full, even in a pop cycle.
//  - FIFO write: {s_q[11:0], s_i[11:0]} on accept. Simultaneous push and pop keeps the
//    level unchanged. Pointers wrap modulo depth.
//  - FSM:
//    IDLE  -> PRIME when tx_en=1.
//    PRIME -> RUN when registered fifo_level >= PRIME_LVL. Outputs stay 0 and frm=0.
//    RUN   pops one sample per cycle; d_he/d_le are loaded with Q/I and frm_he=frm_le=1
//          at the same edge.
//    RUN with fifo_level==0: no pop; d_*=0 and frm_*=0 next cycle; underflow=1 for one
//          cycle; cnt += 1, saturating at 16'hFFFF; -> PRIME. A write in this same cycle
//          does not prevent the underflow, and that sample is retained.
//    Any state with tx_en=0 -> IDLE at next edge: FIFO flushed (level 0), d_*/frm_*=0,
//          no accept possible (s_ready low).
//  - Latency: a sample that brings the level to PRIME_LVL, accepted at edge E, puts the
//    first sample on d_*/frm_* after edge E+2. Samples then appear on consecutive cycles
//    in FIFO order.
//  - cnt_clr: underflow_cnt=0 next edge. cnt_clr wins over a simultaneous underflow.
//  - All outputs registered except s_ready.
//  - Reset mid-stream returns to the reset state immediately. No partial frame is held.
// TESTING
//  - Reset, tx_en=0, s_valid=1 -> s_ready=0, d_*=0, frm_*=0, fifo_level=0.
//  - tx_en=1, push I=1..4, Q=0x101..0x104 back-to-back -> after E+2 of the 4th push:
//    d_le=1, d_he=0x101, frm=1, continuing 2,3,4 on successive cycles.
//  - Stop pushing after 4 samples -> 5th RUN cycle: d=0, frm=0, underflow pulse, cnt=1,
//    state PRIME. Refill 4 -> resumes with no sample lost.
//  - Hold s_valid=1 with no drain (PRIME_LVL=8 case, or tx_en just set) -> accept exactly
//    8, then s_ready=0 with level=8.
//  - Force 0xFFFF underflows -> cnt saturates. Assert cnt_clr and underflow in the same
//    cycle -> cnt=0.
//  - Deassert tx_en mid-RUN with level=5 -> next cycle level=0, frm=0, state IDLE.
//    Async reset mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/ad9361_tx_framer.sv
// AD9361 CMOS DDR transmit framer: an I/Q sample FIFO plus a priming state machine
// that feeds per-phase data and TX_FRAME values to external ODDR primitives.
module ad9361_tx_framer #(
  parameter int FIFO_AW   = 3,
  parameter int PRIME_LVL = 4
) (
  input  logic               sys_clk,
  input  logic               sys_nrst,
  input  logic               tx_en,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [15:0]        s_i,
  input  logic [15:0]        s_q,
  output logic [11:0]        d_he,
  output logic [11:0]        d_le,
  output logic               frm_he,
  output logic               frm_le,
  output logic               tx_active,
  output logic               underflow,
  output logic [15:0]        underflow_cnt,
  input  logic               cnt_clr,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t               state_q;
  logic [23:0]          mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     level_q;
  logic [11:0]          d_he_q, d_le_q;
  logic                 frm_q, tx_active_q, underflow_q;
  logic [15:0]          underflow_cnt_q;

  logic                 push, pop, starve;
  logic [23:0]          rd_data;

  // s_ready looks only at the registered level, so a pop never unblocks a full FIFO early.
  assign s_ready = tx_en && (level_q < LW'(DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = tx_en && (state_q == RUN) && (level_q != '0);
  assign starve  = tx_en && (state_q == RUN) && (level_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_q[11:0], s_i[11:0]};
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      d_he_q          <= '0;
      d_le_q          <= '0;
      frm_q           <= 1'b0;
      tx_active_q     <= 1'b0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      underflow_q <= starve;

      if (cnt_clr)
        underflow_cnt_q <= '0;
      else if (starve && underflow_cnt_q != 16'hFFFF)
        underflow_cnt_q <= underflow_cnt_q + 16'd1;

      if (!tx_en) begin
        state_q     <= IDLE;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        level_q     <= '0;
        d_he_q      <= '0;
        d_le_q      <= '0;
        frm_q       <= 1'b0;
        tx_active_q <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(push);
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(pop);
        level_q  <= level_q + LW'(push) - LW'(pop);

        d_he_q <= '0;
        d_le_q <= '0;
        frm_q  <= 1'b0;
        unique case (state_q)
          IDLE: begin
            state_q     <= PRIME;
            tx_active_q <= 1'b0;
          end
          PRIME: begin
            if (level_q >= LW'(PRIME_LVL)) begin
              state_q     <= RUN;
              tx_active_q <= 1'b1;
            end
          end
          RUN: begin
            if (pop) begin
              d_he_q <= rd_data[23:12];
              d_le_q <= rd_data[11:0];
              frm_q  <= 1'b1;
            end else begin
              // Starved: drop frame and re-prime so the next burst starts cleanly.
              state_q     <= PRIME;
              tx_active_q <= 1'b0;
            end
          end
          default: begin
            state_q     <= IDLE;
            tx_active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign d_he          = d_he_q;
  assign d_le          = d_le_q;
  assign frm_he        = frm_q;
  assign frm_le        = frm_q;
  assign tx_active     = tx_active_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = underflow_cnt_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_ad9361_tx_framer.sv
// Self-checking bench for ad9361_tx_framer: directed phases plus random traffic,
// compared each cycle against a queue-based model of the framer's behaviour.
module tb_ad9361_tx_framer;

  logic        sys_clk = 1'b0;
  logic        sys_nrst = 1'b0;
  logic        tx_en = 1'b0, s_valid = 1'b0, cnt_clr = 1'b0;
  logic [15:0] s_i = '0, s_q = '0;
  logic        s_ready, frm_he, frm_le, tx_active, underflow;
  logic [11:0] d_he, d_le;
  logic [15:0] underflow_cnt;
  logic [3:0]  fifo_level;

  logic        f_ready, f_frm_he, f_frm_le, f_active, f_uf;
  logic [11:0] f_d_he, f_d_le;
  logic [15:0] f_cnt;
  logic [3:0]  f_level;

  always #5 sys_clk = ~sys_clk;

  ad9361_tx_framer #(.FIFO_AW(3), .PRIME_LVL(4)) dut (
    .sys_clk(sys_clk), .sys_nrst(sys_nrst), .tx_en(tx_en), .s_valid(s_valid),
    .s_ready(s_ready), .s_i(s_i), .s_q(s_q), .d_he(d_he), .d_le(d_le),
    .frm_he(frm_he), .frm_le(frm_le), .tx_active(tx_active), .underflow(underflow),
    .underflow_cnt(underflow_cnt), .cnt_clr(cnt_clr), .fifo_level(fifo_level)
  );

  ad9361_tx_framer #(.FIFO_AW(3), .PRIME_LVL(8)) u_full (
    .sys_clk(sys_clk), .sys_nrst(sys_nrst), .tx_en(tx_en), .s_valid(s_valid),
    .s_ready(f_ready), .s_i(s_i), .s_q(s_q), .d_he(f_d_he), .d_le(f_d_le),
    .frm_he(f_frm_he), .frm_le(f_frm_le), .tx_active(f_active), .underflow(f_uf),
    .underflow_cnt(f_cnt), .cnt_clr(cnt_clr), .fifo_level(f_level)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: sample queue, operating mode and counter.
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2;
  logic [23:0] mq[$];
  int          mst = M_IDLE;
  logic [15:0] mcnt = '0;
  logic [23:0] exp_d = '0;
  bit          exp_frm = 0, exp_uf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mst = M_IDLE;
    mcnt = '0;
    exp_d = '0;
    exp_frm = 0;
    exp_uf = 0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ":d_he"}, 32'(d_he), 32'(exp_d[23:12]));
    chk({ph, ":d_le"}, 32'(d_le), 32'(exp_d[11:0]));
    chk({ph, ":frm_he"}, 32'(frm_he), 32'(exp_frm));
    chk({ph, ":frm_le"}, 32'(frm_le), 32'(exp_frm));
    chk({ph, ":underflow"}, 32'(underflow), 32'(exp_uf));
    chk({ph, ":cnt"}, 32'(underflow_cnt), 32'(mcnt));
    chk({ph, ":level"}, 32'(fifo_level), 32'(mq.size()));
    chk({ph, ":tx_active"}, 32'(tx_active), 32'(mst == M_RUN));
  endtask

  // One clock cycle: drive, check s_ready, advance model across the edge, check outputs.
  task automatic step(input bit en, input bit vld, input bit clr,
                      input logic [15:0] si, input logic [15:0] sq);
    bit exp_ready, acc;
    tx_en = en; s_valid = vld; cnt_clr = clr; s_i = si; s_q = sq;
    #1;
    exp_ready = en && (mq.size() < 8);
    chk("s_ready", 32'(s_ready), 32'(exp_ready));
    @(posedge sys_clk);
    acc = vld && exp_ready;
    exp_uf = 0; exp_frm = 0; exp_d = '0;
    if (!en) begin
      mq.delete();
      mst = M_IDLE;
    end else begin
      case (mst)
        M_IDLE:  mst = M_PRIME;
        M_PRIME: if (mq.size() >= 4) mst = M_RUN;
        default: begin
          if (mq.size() > 0) begin
            exp_d = mq.pop_front();
            exp_frm = 1;
          end else begin
            exp_uf = 1;
            mst = M_PRIME;
          end
        end
      endcase
      if (acc) mq.push_back({sq[11:0], si[11:0]});
    end
    if (clr) mcnt = '0;
    else if (exp_uf && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    #1;
    check_outputs("cyc");
    if (exp_frm) $display("tx sample t=%0t I=%h Q=%h", $time, d_le, d_he);
  endtask

  task automatic rstep(input bit en, input bit vld, input bit clr);
    step(en, vld, clr, 16'($urandom), 16'($urandom));
  endtask

  task automatic async_reset();
    sys_nrst = 1'b0;
    #1;
    model_reset();
    chk("arst:d_he", 32'(d_he), 32'd0);
    chk("arst:d_le", 32'(d_le), 32'd0);
    chk("arst:frm", 32'({frm_he, frm_le}), 32'd0);
    chk("arst:tx_active", 32'(tx_active), 32'd0);
    chk("arst:level", 32'(fifo_level), 32'd0);
    chk("arst:cnt", 32'(underflow_cnt), 32'd0);
    #2;
    sys_nrst = 1'b1;
  endtask

  initial begin
    // Reset state with transmit disabled and a pending sample.
    s_valid = 1'b1;
    #12;
    chk("rst:s_ready", 32'(s_ready), 32'd0);
    check_outputs("rst");
    sys_nrst = 1'b1;

    // Directed: four samples, E+2 latency, then starvation.
    for (int k = 1; k <= 4; k++)
      step(1, 1, 0, {4'hA, 12'(k)}, {4'h5, 12'(12'h100 + k)});
    step(1, 0, 0, 16'h0, 16'h0);
    chk("lat:frm_before", 32'(frm_he), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 0, 16'h0, 16'h0);
      chk("lat:d_le", 32'(d_le), 32'(k));
      chk("lat:d_he", 32'(d_he), 32'(12'h100 + k));
    end
    step(1, 0, 0, 16'h0, 16'h0);
    chk("uf:pulse", 32'(underflow), 32'd1);
    chk("uf:cnt", 32'(underflow_cnt), 32'd1);
    chk("uf:frm", 32'(frm_le), 32'd0);
    step(1, 0, 0, 16'h0, 16'h0);
    chk("uf:one_cycle", 32'(underflow), 32'd0);

    // Refill resumes with no lost sample (model checks the order).
    for (int k = 5; k <= 8; k++) step(1, 1, 0, 16'(k), 16'(16'h100 + k));
    for (int k = 0; k < 6; k++) rstep(1, 0, 0);

    // Counter saturation: preload near the top, then drive real starvation events.
    @(negedge sys_clk);
    force dut.underflow_cnt_q = 16'hFFFE;
    #1;
    release dut.underflow_cnt_q;
    mcnt = 16'hFFFE;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) rstep(1, 1, 0);
      for (int k = 0; k < 6; k++) rstep(1, 0, 0);
    end
    chk("sat:cnt", 32'(underflow_cnt), 32'hFFFF);
    for (int k = 0; k < 4; k++) rstep(1, 1, 0);
    for (int k = 0; k < 5; k++) rstep(1, 0, 0);
    rstep(1, 0, 1);
    chk("clr:uf", 32'(underflow), 32'd1);
    chk("clr:cnt", 32'(underflow_cnt), 32'd0);

    // Continuous stream settles at level 5; dropping tx_en flushes.
    for (int k = 0; k < 8; k++) rstep(1, 1, 0);
    chk("stream:level", 32'(fifo_level), 32'd5);
    chk("stream:active", 32'(tx_active), 32'd1);
    rstep(0, 1, 0);
    chk("flush:level", 32'(fifo_level), 32'd0);
    chk("flush:frm", 32'(frm_he), 32'd0);
    chk("flush:active", 32'(tx_active), 32'd0);

    // Fill without drain on the PRIME_LVL=8 instance.
    async_reset();
    for (int k = 1; k <= 9; k++) begin
      rstep(1, 1, 0);
      chk("full:level", 32'(f_level), 32'(k < 8 ? k : 8));
      chk("full:ready", 32'(f_ready), 32'(k < 8));
    end

    // Random traffic.
    for (int k = 0; k < 600; k++)
      rstep(($urandom % 40) != 0, ($urandom % 10) < 7, ($urandom % 50) == 0);

    // Async reset mid-stream.
    for (int k = 0; k < 8; k++) rstep(1, 1, 0);
    chk("pre_arst:active", 32'(tx_active), 32'd1);
    async_reset();
    for (int k = 0; k < 4; k++) rstep(1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
